// File: rtl/jtframe_dump_trig.sv
// jtframe_dump_trig: frame-window trigger generator for waveform capture.
// Counts frames on VS falling edges and runs CHANNELS independent capture
// windows (start frame, length, repeat period). Each window's open and close
// is reported as a level plus one-cycle start/stop pulses.
// Optional build macro DUMP_LOADROM_EN: arm on the first falling edge of
// `downloading` after reset instead of right after reset.
module jtframe_dump_trig #(
    parameter int unsigned CHANNELS = 2,
    parameter int unsigned CNTW     = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     vs,
    input  logic                     downloading,
    input  logic [CHANNELS*CNTW-1:0] ch_start,
    input  logic [CHANNELS*CNTW-1:0] ch_len,
    input  logic [CHANNELS*CNTW-1:0] ch_period,
    output logic                     armed,
    output logic [CNTW-1:0]          frame_cnt,
    output logic [CHANNELS-1:0]      dump_on,
    output logic [CHANNELS-1:0]      dump_start,
    output logic [CHANNELS-1:0]      dump_stop
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WAIT   = 2'd1,
        ACTIVE = 2'd2,
        DONE   = 2'd3
    } ch_state_t;

    logic            vs_l;
    logic            tick;
    logic            arm;
    logic [CNTW-1:0] cnt_nx;

    // Frame tick on VS falling edge; vs_l resets high so no false tick
    assign tick   = vs_l & ~vs;
    assign cnt_nx = (&frame_cnt) ? frame_cnt : frame_cnt + 1'b1;

`ifdef DUMP_LOADROM_EN
    logic dl_l;

    // Arm on the first downloading falling edge; later edges are ignored
    assign arm = ~armed & dl_l & ~downloading;

    // Delayed copy of downloading for edge detection
    always_ff @(posedge clk) begin
        if (rst) dl_l <= 1'b0;
        else     dl_l <= downloading;
    end
`else
    logic unused_downloading;

    assign unused_downloading = downloading;
    // Arm on the first clock after reset is released
    assign arm = ~armed;
`endif

    // VS delay register, arm flag and saturating frame counter
    always_ff @(posedge clk) begin
        if (rst) begin
            vs_l      <= 1'b1;
            armed     <= 1'b0;
            frame_cnt <= '0;
        end else begin
            vs_l <= vs;
            if (arm) begin
                armed     <= 1'b1;
                frame_cnt <= '0;
            end else if (armed && tick) begin
                frame_cnt <= cnt_nx;
            end
        end
    end

    for (genvar n = 0; n < CHANNELS; n++) begin : g_ch
        ch_state_t       st, st_nx;
        logic [CNTW-1:0] start_r, start_nx;
        logic [CNTW-1:0] len_r, len_nx;
        logic [CNTW-1:0] period_r, period_nx;
        logic [CNTW-1:0] rem, rem_nx;
        logic [CNTW:0]   sum;
        logic            open, close;
        logic            on_r, start_p, stop_p;

        // Next-state logic: window open/close decisions and config latch
        always_comb begin
            st_nx     = st;
            start_nx  = start_r;
            len_nx    = len_r;
            period_nx = period_r;
            rem_nx    = rem;
            open      = 1'b0;
            close     = 1'b0;
            sum       = {1'b0, start_r} + {1'b0, period_r};
            case (st)
                IDLE: begin
                    if (arm) begin
                        st_nx     = WAIT;
                        start_nx  = ch_start[n*CNTW +: CNTW];
                        len_nx    = ch_len[n*CNTW +: CNTW];
                        period_nx = ch_period[n*CNTW +: CNTW];
                    end
                end
                WAIT: begin
                    if (tick && cnt_nx >= start_r) begin
                        st_nx  = ACTIVE;
                        rem_nx = len_r;
                        open   = 1'b1;
                    end
                end
                ACTIVE: begin
                    if (tick && len_r != '0) begin
                        if (rem == CNTW'(1)) begin
                            close  = 1'b1;
                            rem_nx = '0;
                            // Overflowing next start cannot be reached: finish instead
                            if (period_r == '0 || sum[CNTW]) begin
                                st_nx = DONE;
                            end else begin
                                st_nx    = WAIT;
                                start_nx = sum[CNTW-1:0];
                            end
                        end else begin
                            rem_nx = rem - 1'b1;
                        end
                    end
                end
                default: st_nx = DONE;
            endcase
        end

        // Channel state and registered outputs
        always_ff @(posedge clk) begin
            if (rst) begin
                st       <= IDLE;
                start_r  <= '0;
                len_r    <= '0;
                period_r <= '0;
                rem      <= '0;
                on_r     <= 1'b0;
                start_p  <= 1'b0;
                stop_p   <= 1'b0;
            end else begin
                st       <= st_nx;
                start_r  <= start_nx;
                len_r    <= len_nx;
                period_r <= period_nx;
                rem      <= rem_nx;
                on_r     <= (st_nx == ACTIVE);
                start_p  <= open;
                stop_p   <= close;
            end
        end

        assign dump_on[n]    = on_r;
        assign dump_start[n] = start_p;
        assign dump_stop[n]  = stop_p;
    end

endmodule

// File: tb/tb_jtframe_dump_trig.sv
// Directed self-checking bench for jtframe_dump_trig: a 2-channel 32-bit
// instance and a 1-channel 4-bit instance share clock, reset and VS.
module tb_jtframe_dump_trig;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        vs = 1'b1;
    logic        downloading = 1'b0;
    logic [63:0] ch_start = '0, ch_len = '0, ch_period = '0;
    logic        armed;
    logic [31:0] frame_cnt;
    logic [1:0]  dump_on, dump_start, dump_stop;
    logic [3:0]  s4_start = '0, s4_len = '0, s4_period = '0;
    logic        armed4;
    logic [3:0]  frame_cnt4;
    logic        on4, start4, stop4;

    int errors = 0;
    int checks = 0;

    // Snapshots taken by tick(): right after the tick edge and one cycle later
    logic [1:0]  s_on, s_st, s_sp, s_extra;
    logic        t_on, t_st, t_sp, t_extra;

    always #5 clk = ~clk;

    jtframe_dump_trig #(.CHANNELS(2), .CNTW(32)) dut (
        .clk(clk), .rst(rst), .vs(vs), .downloading(downloading),
        .ch_start(ch_start), .ch_len(ch_len), .ch_period(ch_period),
        .armed(armed), .frame_cnt(frame_cnt),
        .dump_on(dump_on), .dump_start(dump_start), .dump_stop(dump_stop)
    );

    jtframe_dump_trig #(.CHANNELS(1), .CNTW(4)) dut4 (
        .clk(clk), .rst(rst), .vs(vs), .downloading(downloading),
        .ch_start(s4_start), .ch_len(s4_len), .ch_period(s4_period),
        .armed(armed4), .frame_cnt(frame_cnt4),
        .dump_on(on4), .dump_start(start4), .dump_stop(stop4)
    );

    task automatic tick();
        vs = 1'b0;
        @(negedge clk);
        s_on = dump_on; s_st = dump_start; s_sp = dump_stop;
        t_on = on4;     t_st = start4;     t_sp = stop4;
        vs = 1'b1;
        @(negedge clk);
        s_extra = dump_start | dump_stop;
        t_extra = start4 | stop4;
    endtask

    task automatic do_reset();
        rst = 1'b1; vs = 1'b1; downloading = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
`ifdef DUMP_LOADROM_EN
        downloading = 1'b1;
        @(negedge clk);
        downloading = 1'b0;
        @(negedge clk);
`endif
    endtask

    task automatic test_reset();
        rst = 1'b1; vs = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if ({armed, frame_cnt, dump_on, dump_start, dump_stop} !== 39'd0) begin
            errors++;
            $display("FAIL reset_state: got armed=%b cnt=%0d on=%b st=%b sp=%b expected all 0",
                     armed, frame_cnt, dump_on, dump_start, dump_stop);
        end
        do_reset();
        checks++;
        if (armed !== 1'b1 || frame_cnt !== 32'd0) begin
            errors++;
            $display("FAIL arm_after_reset: got armed=%b cnt=%0d expected armed=1 cnt=0", armed, frame_cnt);
        end
    endtask

    // start=3 len=2 period=0: open after tick 3, close after tick 5, then done
    task automatic test_single_shot();
        logic [31:0] on_m, st_m, sp_m, ex_m;
        on_m = '0; st_m = '0; sp_m = '0; ex_m = '0;
        ch_start = {32'hFFFF_FFFF, 32'd3}; ch_len = {32'd1, 32'd2}; ch_period = '0;
        do_reset();
        for (int f = 1; f <= 8; f++) begin
            tick();
            on_m[f] = s_on[0]; st_m[f] = s_st[0]; sp_m[f] = s_sp[0];
            ex_m[f] = s_extra[0];
        end
        checks++;
        if (on_m !== 32'h0000_0018) begin errors++; $display("FAIL single_on: got %h expected %h", on_m, 32'h18); end
        checks++;
        if (st_m !== 32'h0000_0008) begin errors++; $display("FAIL single_start: got %h expected %h", st_m, 32'h08); end
        checks++;
        if (sp_m !== 32'h0000_0020) begin errors++; $display("FAIL single_stop: got %h expected %h", sp_m, 32'h20); end
        checks++;
        if (ex_m !== 32'h0) begin errors++; $display("FAIL single_late_pulse: got %h expected 0", ex_m); end
        checks++;
        if (frame_cnt !== 32'd8) begin errors++; $display("FAIL single_cnt: got %0d expected 8", frame_cnt); end
    endtask

    // start=2 len=1 period=4: windows at 2, 6, 10; input changes after arm ignored
    task automatic test_periodic();
        logic [31:0] on_m, st_m, sp_m;
        on_m = '0; st_m = '0; sp_m = '0;
        ch_start = {32'hFFFF_FFFF, 32'd2}; ch_len = {32'd1, 32'd1}; ch_period = {32'd0, 32'd4};
        do_reset();
        ch_start = '0; ch_len = '0; ch_period = '0;
        for (int f = 1; f <= 12; f++) begin
            tick();
            on_m[f] = s_on[0]; st_m[f] = s_st[0]; sp_m[f] = s_sp[0];
        end
        checks++;
        if (on_m !== 32'h0000_0444) begin errors++; $display("FAIL periodic_on: got %h expected %h", on_m, 32'h444); end
        checks++;
        if (st_m !== 32'h0000_0444) begin errors++; $display("FAIL periodic_start: got %h expected %h", st_m, 32'h444); end
        checks++;
        if (sp_m !== 32'h0000_0888) begin errors++; $display("FAIL periodic_stop: got %h expected %h", sp_m, 32'h888); end
    endtask

    // CNTW=4, start=0 len=0: counter saturates at 15, window never closes
    task automatic test_unbounded_sat();
        logic [31:0] on_m, st_m, sp_m;
        on_m = '0; st_m = '0; sp_m = '0;
        s4_start = 4'd0; s4_len = 4'd0; s4_period = 4'd0;
        do_reset();
        for (int f = 1; f <= 20; f++) begin
            tick();
            on_m[f] = t_on; st_m[f] = t_st; sp_m[f] = t_sp | t_extra;
        end
        checks++;
        if (frame_cnt4 !== 4'd15) begin errors++; $display("FAIL sat_cnt: got %0d expected 15", frame_cnt4); end
        checks++;
        if (on_m !== 32'h001F_FFFE) begin errors++; $display("FAIL sat_on: got %h expected %h", on_m, 32'h1FFFFE); end
        checks++;
        if (st_m !== 32'h0000_0002) begin errors++; $display("FAIL sat_start: got %h expected %h", st_m, 32'h2); end
        checks++;
        if (sp_m !== 32'h0) begin errors++; $display("FAIL sat_stop: got %h expected 0", sp_m); end
    endtask

    // CNTW=4, start=14 len=1 period=3: second start 17 overflows, no reopen
    task automatic test_period_overflow();
        logic [31:0] on_m, st_m, sp_m;
        on_m = '0; st_m = '0; sp_m = '0;
        s4_start = 4'd14; s4_len = 4'd1; s4_period = 4'd3;
        do_reset();
        for (int f = 1; f <= 20; f++) begin
            tick();
            on_m[f] = t_on; st_m[f] = t_st; sp_m[f] = t_sp;
        end
        checks++;
        if (on_m !== 32'h0000_4000) begin errors++; $display("FAIL ovf_on: got %h expected %h", on_m, 32'h4000); end
        checks++;
        if (st_m !== 32'h0000_4000) begin errors++; $display("FAIL ovf_start: got %h expected %h", st_m, 32'h4000); end
        checks++;
        if (sp_m !== 32'h0000_8000) begin errors++; $display("FAIL ovf_stop: got %h expected %h", sp_m, 32'h8000); end
    endtask

    // ch0 start=1 len=3, ch1 start=2 len=1; reset mid-window drops everything
    task automatic test_two_channels_reset();
        logic [1:0] exp_on [3]; logic [1:0] exp_st [3]; logic [1:0] exp_sp [3];
        exp_on = '{2'b01, 2'b11, 2'b01};
        exp_st = '{2'b01, 2'b10, 2'b00};
        exp_sp = '{2'b00, 2'b00, 2'b10};
        ch_start = {32'd2, 32'd1}; ch_len = {32'd1, 32'd3}; ch_period = '0;
        do_reset();
        for (int f = 0; f < 3; f++) begin
            tick();
            checks++;
            if ({s_on, s_st, s_sp} !== {exp_on[f], exp_st[f], exp_sp[f]}) begin
                errors++;
                $display("FAIL two_ch_frame%0d: got on=%b st=%b sp=%b expected on=%b st=%b sp=%b",
                         f + 1, s_on, s_st, s_sp, exp_on[f], exp_st[f], exp_sp[f]);
            end
        end
        rst = 1'b1;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            checks++;
            if ({armed, frame_cnt, dump_on, dump_start, dump_stop} !== 39'd0) begin
                errors++;
                $display("FAIL mid_reset_c%0d: got armed=%b cnt=%0d on=%b st=%b sp=%b expected all 0",
                         c, armed, frame_cnt, dump_on, dump_start, dump_stop);
            end
        end
        rst = 1'b0;
    endtask

`ifdef DUMP_LOADROM_EN
    // Arming waits for downloading to fall; the tick in the arm cycle is dropped
    task automatic test_loadrom();
        ch_start = {32'hFFFF_FFFF, 32'd2}; ch_len = {32'd1, 32'd1}; ch_period = '0;
        rst = 1'b1; downloading = 1'b1; vs = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        for (int f = 0; f < 10; f++) tick();
        checks++;
        if (armed !== 1'b0 || frame_cnt !== 32'd0) begin
            errors++;
            $display("FAIL lr_unarmed: got armed=%b cnt=%0d expected 0 0", armed, frame_cnt);
        end
        downloading = 1'b0; vs = 1'b0;
        @(negedge clk);
        vs = 1'b1;
        @(negedge clk);
        checks++;
        if (armed !== 1'b1 || frame_cnt !== 32'd0) begin
            errors++;
            $display("FAIL lr_arm: got armed=%b cnt=%0d expected 1 0", armed, frame_cnt);
        end
        downloading = 1'b1;
        tick();
        checks++;
        if (s_on[0] !== 1'b0 || frame_cnt !== 32'd1) begin
            errors++;
            $display("FAIL lr_tick1: got on=%b cnt=%0d expected 0 1", s_on[0], frame_cnt);
        end
        tick();
        checks++;
        if (s_on[0] !== 1'b1 || s_st[0] !== 1'b1) begin
            errors++;
            $display("FAIL lr_tick2: got on=%b st=%b expected 1 1", s_on[0], s_st[0]);
        end
        downloading = 1'b0;
    endtask
`endif

    initial begin
        test_reset();
        test_single_shot();
        test_periodic();
        test_unbounded_sat();
        test_period_overflow();
        test_two_channels_reset();
`ifdef DUMP_LOADROM_EN
        test_loadrom();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
